// File: rtl/tvm_buffer_pkg.sv
// tvm_buffer_pkg: shared FSM state encoding and address width helper for tvm_buffer blocks
package tvm_buffer_pkg;
  typedef enum logic [1:0] {FILL, PAD, ADV} state_t;
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tvm_buffer_window_writer.sv
// tvm_buffer_window_writer: streams words into the buffer's write window, pads on last, then advances
module tvm_buffer_window_writer
  import tvm_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WR_WINDOW = 4,
  parameter int WR_ADVANCE = 2,
  parameter int WR_ADDR_WIDTH = addr_width(WR_WINDOW),
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic in_last,
  output logic write_valid,
  input  logic write_ready,
  output logic [WR_ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic write_advance,
  output logic busy,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] adv_count
);
  localparam logic [WR_ADDR_WIDTH-1:0] LAST = WR_ADDR_WIDTH'(WR_WINDOW - 1);
  // later windows resume after the overlap slots the buffer keeps
  localparam logic [WR_ADDR_WIDTH-1:0] START = WR_ADDR_WIDTH'(WR_WINDOW - WR_ADVANCE);
  state_t state, state_n;
  logic [WR_ADDR_WIDTH-1:0] ptr, ptr_n;
  logic wr, adv;
  always_comb begin
    in_ready = state == FILL && write_ready;
    write_valid = state == FILL ? in_valid : state == PAD;
    write_data = state == FILL ? in_data : PAD_VALUE;
    write_addr = ptr;
    write_advance = state == ADV;
    busy = state != FILL;
    wr = write_valid && write_ready;
    adv = write_advance && write_ready;
    state_n = state;
    ptr_n = ptr;
    if (wr && ptr == LAST) state_n = ADV;
    else if (wr) begin
      ptr_n = ptr + WR_ADDR_WIDTH'(1);
      state_n = state == FILL && in_last ? PAD : state;
    end
    if (adv) begin
      ptr_n = START;
      state_n = FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      ptr <= '0;
      word_count <= '0;
      adv_count <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      if (wr) word_count <= word_count + CNT_WIDTH'(1);
      if (adv) adv_count <= adv_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_tvm_buffer_window_writer.sv
// tb_tvm_buffer_window_writer: randomized scoreboard bench for the window writer (W=4/A=2 and W=A=1)
module tb_tvm_buffer_window_writer;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, write_ready = 0;
  logic [7:0] in_data = 0;
  logic ir0, wv0, adv0, bz0, ir1, wv1, adv1, bz1;
  logic [1:0] addr0;
  logic [0:0] addr1;
  logic [7:0] wd0, wd1;
  logic [15:0] wc0, ac0, wc1, ac1;
  int checks = 0, errors = 0;
  int src_d[$];
  bit src_l[$];
  int exp_k[$], exp_a[$], exp_d[$], obs_k[$], obs_a[$], obs_d[$];
  int m_slot = 0, m_words = 0, m_advs = 0, viol = 0;
  bit timeout;

  always #5 clk = ~clk;

  tvm_buffer_window_writer dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_last(in_last),
    .write_valid(wv0), .write_ready(write_ready), .write_addr(addr0), .write_data(wd0),
    .write_advance(adv0), .busy(bz0), .word_count(wc0), .adv_count(ac0)
  );

  tvm_buffer_window_writer #(.WR_WINDOW(1), .WR_ADVANCE(1), .WR_ADDR_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_last(in_last),
    .write_valid(wv1), .write_ready(write_ready), .write_addr(addr1), .write_data(wd1),
    .write_advance(adv1), .busy(bz1), .word_count(wc1), .adv_count(ac1)
  );

  // Expected transaction list from the window rules: kind 0 = write (slot,data), kind 1 = advance
  task automatic model(input int w, input int a);
    exp_k.delete(); exp_a.delete(); exp_d.delete();
    for (int i = 0; i < src_d.size(); i++) begin
      exp_k.push_back(0); exp_a.push_back(m_slot); exp_d.push_back(src_d[i]); m_words++;
      if (m_slot == w - 1 || src_l[i]) begin
        for (int s = m_slot + 1; s < w; s++) begin
          exp_k.push_back(0); exp_a.push_back(s); exp_d.push_back(0); m_words++;
        end
        exp_k.push_back(1); exp_a.push_back(0); exp_d.push_back(0); m_advs++;
        m_slot = w - a;
      end else m_slot++;
    end
  endtask

  task automatic run(input bit one, input int vp, input int rp);
    logic wv, wa, ir, bz, p_hold, p_wv, p_wa;
    int ad, dt, p_ad, p_dt;
    p_hold = 0; p_wv = 0; p_wa = 0; p_ad = 0; p_dt = 0;
    obs_k.delete(); obs_a.delete(); obs_d.delete();
    viol = 0; timeout = 1;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      in_valid = src_d.size() > 0 && $urandom_range(99) < vp;
      in_data = src_d.size() > 0 ? 8'(src_d[0]) : 8'($urandom);
      in_last = src_d.size() > 0 ? src_l[0] : 1'($urandom);
      write_ready = $urandom_range(99) < rp;
      @(negedge clk);
      wv = one ? wv1 : wv0; wa = one ? adv1 : adv0; ir = one ? ir1 : ir0; bz = one ? bz1 : bz0;
      ad = one ? int'(addr1) : int'(addr0); dt = one ? int'(wd1) : int'(wd0);
      if (wv && wa) viol++;
      if (bz && ir) viol++;
      if (!bz && (ir !== write_ready || wv !== in_valid)) viol++;
      if (p_hold && (wv !== p_wv || wa !== p_wa || ad != p_ad || dt != p_dt)) viol++;
      p_hold = bz && !write_ready; p_wv = wv; p_wa = wa; p_ad = ad; p_dt = dt;
      if (wv && write_ready) begin obs_k.push_back(0); obs_a.push_back(ad); obs_d.push_back(dt); end
      if (wa && write_ready) begin obs_k.push_back(1); obs_a.push_back(0); obs_d.push_back(0); end
      if (in_valid && ir) begin void'(src_d.pop_front()); void'(src_l.pop_front()); end
      if (src_d.size() == 0 && !bz && !(wv && write_ready)) begin timeout = 0; break; end
    end
    in_valid = 0; in_last = 0; write_ready = 1;
  endtask

  task automatic pulse_reset();
    in_valid = 0; in_last = 0;
    rst = 1; @(posedge clk); #1 rst = 0;
    m_slot = 0; m_words = 0; m_advs = 0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_data = 8'h55; write_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (wc0 !== 16'd0 || ac0 !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", wc0, ac0); end
    checks++;
    if (bz0 !== 1'b0 || adv0 !== 1'b0) begin errors++; $display("FAIL reset_busy_adv got %b/%b want 0/0", bz0, adv0); end
    checks++;
    if (wv0 !== 1'b1 || ir0 !== 1'b0 || addr0 !== 2'd0) begin errors++; $display("FAIL reset_passthru got wv%b ir%b a%0d want wv1 ir0 a0", wv0, ir0, addr0); end
    in_valid = 0; write_ready = 1; #1;
    checks++;
    if (wv0 !== 1'b0 || ir0 !== 1'b1) begin errors++; $display("FAIL reset_ready got wv%b ir%b want wv0 ir1", wv0, ir0); end
    m_slot = 0; m_words = 0; m_advs = 0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin src_d.push_back(8'h10 + i); src_l.push_back(0); end
    model(4, 2);
    run(0, 100, 100);
    checks++;
    if (timeout || obs_k.size() != exp_k.size()) begin errors++; $display("FAIL stream_len got %0d want %0d timeout %0b", obs_k.size(), exp_k.size(), timeout); end
    for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++) begin
      checks++;
      if (obs_k[i] != exp_k[i] || (exp_k[i] == 0 && (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i]))) begin
        errors++; $display("FAIL stream_txn %0d got k%0d a%0d d%02h want k%0d a%0d d%02h", i, obs_k[i], obs_a[i], obs_d[i], exp_k[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (viol != 0 || wc0 !== 16'(m_words) || ac0 !== 16'(m_advs)) begin errors++; $display("FAIL stream_cnt got wc%0d ac%0d viol%0d want wc%0d ac%0d viol0", wc0, ac0, viol, m_words, m_advs); end
  endtask

  task automatic test_pad();
    src_d.push_back(8'h20); src_l.push_back(1);
    model(4, 2);
    run(0, 100, 100);
    checks++;
    if (timeout || obs_k.size() != exp_k.size()) begin errors++; $display("FAIL pad_len got %0d want %0d timeout %0b", obs_k.size(), exp_k.size(), timeout); end
    for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++) begin
      checks++;
      if (obs_k[i] != exp_k[i] || (exp_k[i] == 0 && (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i]))) begin
        errors++; $display("FAIL pad_txn %0d got k%0d a%0d d%02h want k%0d a%0d d%02h", i, obs_k[i], obs_a[i], obs_d[i], exp_k[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (viol != 0 || wc0 !== 16'(m_words) || ac0 !== 16'(m_advs)) begin errors++; $display("FAIL pad_cnt got wc%0d ac%0d viol%0d want wc%0d ac%0d viol0", wc0, ac0, viol, m_words, m_advs); end
  endtask

  // Window starts at slot 2 here, so two words fill it and leave the writer in ADV
  task automatic test_backpressure();
    @(posedge clk); #1 in_valid = 1; in_data = 8'h30; in_last = 0; write_ready = 1;
    @(posedge clk); #1 in_data = 8'h31;
    @(posedge clk); #1 in_valid = 0; write_ready = 0;
    m_words += 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (adv0 !== 1'b1 || addr0 !== 2'd3 || ac0 !== 16'(m_advs) || ir0 !== 1'b0 || wv0 !== 1'b0 || wc0 !== 16'(m_words)) begin
        errors++; $display("FAIL bp_hold cyc%0d got adv%b a%0d ac%0d ir%b wv%b wc%0d want adv1 a3 ac%0d ir0 wv0 wc%0d", i, adv0, addr0, ac0, ir0, wv0, wc0, m_advs, m_words);
      end
      @(posedge clk); #1;
    end
    write_ready = 1;
    @(negedge clk);
    checks++;
    if (adv0 !== 1'b1) begin errors++; $display("FAIL bp_ready got adv%b want adv1", adv0); end
    @(posedge clk); #1;
    m_advs++; m_slot = 2;
    checks++;
    if (adv0 !== 1'b0 || ac0 !== 16'(m_advs) || addr0 !== 2'd2 || bz0 !== 1'b0) begin
      errors++; $display("FAIL bp_done got adv%b ac%0d a%0d bz%b want adv0 ac%0d a2 bz0", adv0, ac0, addr0, bz0, m_advs);
    end
  endtask

  task automatic test_last_slot3();
    src_d.push_back(8'h40); src_l.push_back(0);
    src_d.push_back(8'h41); src_l.push_back(1);
    src_d.push_back(8'h42); src_l.push_back(0);
    model(4, 2);
    run(0, 80, 70);
    checks++;
    if (timeout || obs_k.size() != exp_k.size()) begin errors++; $display("FAIL last3_len got %0d want %0d timeout %0b", obs_k.size(), exp_k.size(), timeout); end
    for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++) begin
      checks++;
      if (obs_k[i] != exp_k[i] || (exp_k[i] == 0 && (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i]))) begin
        errors++; $display("FAIL last3_txn %0d got k%0d a%0d d%02h want k%0d a%0d d%02h", i, obs_k[i], obs_a[i], obs_d[i], exp_k[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (viol != 0 || wc0 !== 16'(m_words) || ac0 !== 16'(m_advs)) begin errors++; $display("FAIL last3_cnt got wc%0d ac%0d viol%0d want wc%0d ac%0d viol0", wc0, ac0, viol, m_words, m_advs); end
  endtask

  task automatic test_reset_mid_pad();
    pulse_reset();
    write_ready = 1; in_valid = 1; in_data = 8'h50; in_last = 1;
    @(posedge clk); #1 in_valid = 0; in_last = 0;
    @(negedge clk);
    checks++;
    if (bz0 !== 1'b1 || wv0 !== 1'b1 || addr0 !== 2'd1 || wd0 !== 8'h00 || ir0 !== 1'b0) begin
      errors++; $display("FAIL midpad_state got bz%b wv%b a%0d d%02h ir%b want bz1 wv1 a1 d00 ir0", bz0, wv0, addr0, wd0, ir0);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if (bz0 !== 1'b0 || adv0 !== 1'b0 || wc0 !== 16'd0 || ac0 !== 16'd0 || addr0 !== 2'd0) begin
      errors++; $display("FAIL midpad_reset got bz%b adv%b wc%0d ac%0d a%0d want bz0 adv0 wc0 ac0 a0", bz0, adv0, wc0, ac0, addr0);
    end
    m_slot = 0; m_words = 0; m_advs = 0;
    src_d.push_back(8'h60); src_l.push_back(0);
    model(4, 2);
    run(0, 100, 100);
    checks++;
    if (timeout || obs_k.size() != 1 || obs_k[0] != 0 || obs_a[0] != exp_a[0] || obs_d[0] != exp_d[0]) begin
      errors++; $display("FAIL midpad_next got n%0d a%0d d%02h want n1 a%0d d%02h", obs_k.size(), obs_k.size() ? obs_a[0] : -1, obs_k.size() ? obs_d[0] : 0, exp_a[0], exp_d[0]);
    end
  endtask

  task automatic test_single();
    pulse_reset();
    src_d.push_back(8'hA0); src_l.push_back(0);
    src_d.push_back(8'hA1); src_l.push_back(1);
    model(1, 1);
    run(1, 100, 100);
    checks++;
    if (timeout || obs_k.size() != exp_k.size()) begin errors++; $display("FAIL single_len got %0d want %0d timeout %0b", obs_k.size(), exp_k.size(), timeout); end
    for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++) begin
      checks++;
      if (obs_k[i] != exp_k[i] || (exp_k[i] == 0 && (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i]))) begin
        errors++; $display("FAIL single_txn %0d got k%0d a%0d d%02h want k%0d a%0d d%02h", i, obs_k[i], obs_a[i], obs_d[i], exp_k[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (viol != 0 || wc1 !== 16'(m_words) || ac1 !== 16'(m_advs)) begin errors++; $display("FAIL single_cnt got wc%0d ac%0d viol%0d want wc%0d ac%0d viol0", wc1, ac1, viol, m_words, m_advs); end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      pulse_reset();
      for (int i = 0; i < 150; i++) begin src_d.push_back($urandom_range(255)); src_l.push_back($urandom_range(99) < 20); end
      if (d == 0) model(4, 2); else model(1, 1);
      run(d[0], 70, 60);
      checks++;
      if (timeout || obs_k.size() != exp_k.size()) begin errors++; $display("FAIL rand%0d_len got %0d want %0d timeout %0b", d, obs_k.size(), exp_k.size(), timeout); end
      for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++) begin
        checks++;
        if (obs_k[i] != exp_k[i] || (exp_k[i] == 0 && (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i]))) begin
          errors++; $display("FAIL rand%0d_txn %0d got k%0d a%0d d%02h want k%0d a%0d d%02h", d, i, obs_k[i], obs_a[i], obs_d[i], exp_k[i], exp_a[i], exp_d[i]);
        end
      end
      checks++;
      if (viol != 0 || (d == 0 ? wc0 : wc1) !== 16'(m_words) || (d == 0 ? ac0 : ac1) !== 16'(m_advs)) begin
        errors++; $display("FAIL rand%0d_cnt got wc%0d ac%0d viol%0d want wc%0d ac%0d viol0", d, d == 0 ? wc0 : wc1, d == 0 ? ac0 : ac1, viol, m_words, m_advs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_pad();
    test_backpressure();
    test_last_slot3();
    test_reset_mid_pad();
    test_single();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
